pipeline_arbiter: RTL and testbench

- Shares one address pipeline between NUM_REQ requesters.
- Request side: round-robin arbitration with per-requester outstanding-transaction limits. Drives the pipeline input through one registered output stage.
- Response side: routes each pipeline output beat back to its requester, selected by the requester index the arbiter embeds in the ID MSBs.
- Sits directly in front of and behind the pipeline, using the same valid/stall handshake.

---
 rtl/pipeline_arbiter_if.sv | 48 ++++
 rtl/pipeline_arbiter.sv | 132 +++++++++++++
 tb/tb_pipeline_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_arbiter_if.sv
// Bundle of the requester, pipeline-input, pipeline-output and response links
// around pipeline_arbiter; master is the arbiter's view, slave the environment's.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

interface pipeline_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int IDX_W         = 2,
  parameter int ADDRESS_WIDTH = `ADDRESS_WIDTH,
  parameter int ID_WIDTH      = `ID_WIDTH
);
  // Every link uses valid/stall: a beat moves in a cycle where valid=1 and
  // stall=0; while stalled, the sender holds valid and its payload stable.
  logic [NUM_REQ*ADDRESS_WIDTH-1:0]    req_address;
  logic [NUM_REQ*(ID_WIDTH-IDX_W)-1:0] req_id;
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_stall;
  logic [ADDRESS_WIDTH-1:0]            pipe_address;
  logic [ID_WIDTH-1:0]                 pipe_id;
  logic                                pipe_valid;
  logic                                pipe_stall;
  logic [ADDRESS_WIDTH-1:0]            ret_address;
  logic [ID_WIDTH-1:0]                 ret_id;
  logic                                ret_valid;
  logic                                ret_stall;
  logic [ADDRESS_WIDTH-1:0]            resp_address;
  logic [ID_WIDTH-1:0]                 resp_id;
  logic [NUM_REQ-1:0]                  resp_valid;
  logic [NUM_REQ-1:0]                  resp_stall;

  modport master (
    input  req_address, req_id, req_valid, pipe_stall,
    input  ret_address, ret_id, ret_valid, resp_stall,
    output req_stall, pipe_address, pipe_id, pipe_valid,
    output ret_stall, resp_address, resp_id, resp_valid
  );

  modport slave (
    output req_address, req_id, req_valid, pipe_stall,
    output ret_address, ret_id, ret_valid, resp_stall,
    input  req_stall, pipe_address, pipe_id, pipe_valid,
    input  ret_stall, resp_address, resp_id, resp_valid
  );
endinterface

// File: rtl/pipeline_arbiter.sv
// Round-robin front end for a shared address pipeline with per-requester
// outstanding limits, plus the ID-indexed return demux behind it.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module pipeline_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int IDX_W           = 2,
  parameter int ADDRESS_WIDTH   = `ADDRESS_WIDTH,
  parameter int ID_WIDTH        = `ID_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_arbiter_if.master   bus,
  output logic [IDX_W-1:0]     dbg_rr_ptr,
  output logic [NUM_REQ*4-1:0] dbg_cnt
);
  localparam int         LOCAL_W = ID_WIDTH - IDX_W;
  localparam logic [3:0] CNT_MAX = 4'(MAX_OUTSTANDING);

  logic [IDX_W-1:0]         rr_ptr;
  logic [IDX_W-1:0]         grant;
  logic [IDX_W-1:0]         cand;
  logic                     grant_valid;
  logic                     load_en;
  logic                     issue;
  logic [NUM_REQ-1:0]       eligible;
  logic [NUM_REQ-1:0]       req_stall;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       inc;
  logic [NUM_REQ-1:0]       dec;
  logic [IDX_W-1:0]         ret_idx;
  logic [3:0]               cnt [NUM_REQ];
  logic                     pipe_valid_q;
  logic [ADDRESS_WIDTH-1:0] pipe_address_q;
  logic [ID_WIDTH-1:0]      pipe_id_q;

  assign load_en = !pipe_valid_q || !bus.pipe_stall;
  assign issue   = load_en && grant_valid;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = bus.req_valid[i] && (cnt[i] < CNT_MAX);
  end

  // First eligible requester scanning upward from rr_ptr; the index width
  // makes the modulo-NUM_REQ wrap free since NUM_REQ is a power of two.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr + IDX_W'(k);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    req_stall = '1;
    for (int i = 0; i < NUM_REQ; i++)
      req_stall[i] = !(issue && (grant == IDX_W'(i)));
  end

  assign ret_idx = bus.ret_id[ID_WIDTH-1 -: IDX_W];

  always_comb begin
    resp_valid = '0;
    inc        = '0;
    dec        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = bus.ret_valid && (ret_idx == IDX_W'(i));
      inc[i]        = issue && (grant == IDX_W'(i));
      // Returns for an empty counter are stale (e.g. issued before reset).
      dec[i]        = resp_valid[i] && !bus.resp_stall[i] && (cnt[i] != 4'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid_q   <= 1'b0;
      pipe_address_q <= '0;
      pipe_id_q      <= '0;
      rr_ptr         <= '0;
    end else if (load_en) begin
      pipe_valid_q <= grant_valid;
      if (grant_valid) begin
        pipe_address_q <= bus.req_address[int'(grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        pipe_id_q      <= {grant, bus.req_id[int'(grant)*LOCAL_W +: LOCAL_W]};
        rr_ptr         <= grant + IDX_W'(1);
      end
    end
  end

  // Issue and return to the same requester in one cycle cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({inc[i], dec[i]})
          2'b10:   cnt[i] <= cnt[i] + 4'd1;
          2'b01:   cnt[i] <= cnt[i] - 4'd1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_comb begin
    dbg_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) dbg_cnt[i*4 +: 4] = cnt[i];
  end

  assign dbg_rr_ptr       = rr_ptr;
  assign bus.req_stall    = req_stall;
  assign bus.pipe_valid   = pipe_valid_q;
  assign bus.pipe_address = pipe_address_q;
  assign bus.pipe_id      = pipe_id_q;
  assign bus.resp_valid   = resp_valid;
  assign bus.ret_stall    = bus.ret_valid && bus.resp_stall[ret_idx];
  assign bus.resp_address = bus.ret_address;
  assign bus.resp_id      = bus.ret_id;
endmodule

// File: tb/tb_pipeline_arbiter.sv
// Bench for pipeline_arbiter: return-demux vector table, hand-written
// multi-cycle sequences, then random traffic against a behavioural model.
module tb_pipeline_arbiter;
  localparam int NR   = 4;
  localparam int IW   = 2;
  localparam int AW   = 16;
  localparam int IDW  = 8;
  localparam int LW   = IDW - IW;
  localparam int MAXO = 4;

  logic clk;
  logic reset;
  logic [IW-1:0]   dbg_rr_ptr;
  logic [NR*4-1:0] dbg_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_arbiter_if #(.NUM_REQ(NR), .IDX_W(IW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IDW)) bus ();

  pipeline_arbiter #(
    .NUM_REQ(NR), .IDX_W(IW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .dbg_rr_ptr (dbg_rr_ptr),
    .dbg_cnt    (dbg_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drivers
  task automatic idle_inputs();
    bus.req_address = '0;
    bus.req_id      = '0;
    bus.req_valid   = '0;
    bus.pipe_stall  = 1'b0;
    bus.ret_address = '0;
    bus.ret_id      = '0;
    bus.ret_valid   = 1'b0;
    bus.resp_stall  = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [LW-1:0] id);
    bus.req_address[i*AW +: AW] = addr;
    bus.req_id[i*LW +: LW]      = id;
  endtask

  function automatic logic [3:0] cnt_of(input int i);
    return dbg_cnt[i*4 +: 4];
  endfunction

  typedef struct {
    logic       rv;
    logic [1:0] idx;
    logic [3:0] rs;
    logic [3:0] exp_resp_valid;
    logic       exp_ret_stall;
  } ret_vec_t;

  ret_vec_t vecs[8];

  // scoreboard / reference model state
  logic [AW+IDW-1:0] exp_q[$];
  int         m_cnt[NR];
  int         m_ptr;
  logic       m_pv;
  int         g;
  int         ridx;
  bit         load;
  logic [3:0] exp_stall;
  logic [3:0] exp_rv;

  initial begin
    vecs[0] = '{1'b0, 2'd1, 4'b1111, 4'b0000, 1'b0};
    vecs[1] = '{1'b1, 2'd0, 4'b0000, 4'b0001, 1'b0};
    vecs[2] = '{1'b1, 2'd1, 4'b0010, 4'b0010, 1'b1};
    vecs[3] = '{1'b1, 2'd1, 4'b1101, 4'b0010, 1'b0};
    vecs[4] = '{1'b1, 2'd2, 4'b0100, 4'b0100, 1'b1};
    vecs[5] = '{1'b1, 2'd3, 4'b0111, 4'b1000, 1'b0};
    vecs[6] = '{1'b1, 2'd3, 4'b1000, 4'b1000, 1'b1};
    vecs[7] = '{1'b1, 2'd2, 4'b1011, 4'b0100, 1'b0};

    // reset state
    apply_reset();
    #1;
    check("rst_pipe_valid", bus.pipe_valid, 0);
    check("rst_pipe_address", bus.pipe_address, 0);
    check("rst_pipe_id", bus.pipe_id, 0);
    check("rst_req_stall", bus.req_stall, 4'b1111);
    check("rst_ret_stall", bus.ret_stall, 0);
    check("rst_cnt", dbg_cnt, 0);
    check("rst_rr_ptr", dbg_rr_ptr, 0);

    // return demux table (all counters 0, so these returns are stale)
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.ret_valid   = vecs[k].rv;
      bus.ret_id      = {vecs[k].idx, 6'h15};
      bus.ret_address = AW'(16'hA000 + k);
      bus.resp_stall  = vecs[k].rs;
      #1;
      check("tbl_resp_valid", bus.resp_valid, vecs[k].exp_resp_valid);
      check("tbl_ret_stall", bus.ret_stall, vecs[k].exp_ret_stall);
      check("tbl_resp_address", bus.resp_address, 16'hA000 + k);
      check("tbl_resp_id", bus.resp_id, {vecs[k].idx, 6'h15});
    end
    @(negedge clk);
    bus.ret_valid = 1'b0;
    #1 check("tbl_no_underflow", dbg_cnt, 0);

    // fairness: all valid, ids i+5, then reset mid-stream
    apply_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(16'h100 + i), LW'(i + 5));
    bus.req_valid = 4'b1111;
    #1 check("rr_first_stall", bus.req_stall, 4'b1110);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      #1;
      check("rr_pipe_valid", bus.pipe_valid, 1);
      check("rr_pipe_id", bus.pipe_id, {IW'(n % NR), LW'((n % NR) + 5)});
      check("rr_pipe_address", bus.pipe_address, 16'h100 + (n % NR));
      check("rr_next_stall", bus.req_stall, ~(4'b0001 << ((n + 1) % NR)) & 4'hF);
    end
    #2 reset = 1'b0;
    #1;
    check("midrst_pipe_valid", bus.pipe_valid, 0);
    check("midrst_pipe_id", bus.pipe_id, 0);
    check("midrst_cnt", dbg_cnt, 0);
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    bus.ret_valid  = 1'b1;
    bus.ret_id     = {2'd1, 6'h0};
    bus.resp_stall = '0;
    @(negedge clk);
    bus.ret_valid = 1'b0;
    #1 check("midrst_stale_return", dbg_cnt, 0);

    // requester 2 alone hits the outstanding limit
    apply_reset();
    bus.req_valid = 4'b0100;
    for (int n = 0; n < 4; n++) begin
      set_req(2, AW'(16'h10 + n), '0);
      #1 check("lim_stall_open", bus.req_stall, 4'b1011);
      @(negedge clk);
      #1;
      check("lim_pipe_valid", bus.pipe_valid, 1);
      check("lim_pipe_address", bus.pipe_address, 16'h10 + n);
    end
    set_req(2, AW'(16'h14), '0);
    #1;
    check("lim_stall_full", bus.req_stall, 4'b1111);
    check("lim_cnt_full", cnt_of(2), 4);
    @(negedge clk);
    #1 check("lim_no_issue", bus.pipe_valid, 0);
    bus.ret_valid = 1'b1;
    bus.ret_id    = {2'd2, 6'h0};
    #1 check("lim_stall_same_cycle", bus.req_stall, 4'b1111);
    @(negedge clk);
    bus.ret_valid = 1'b0;
    #1 check("lim_stall_reopen", bus.req_stall, 4'b1011);
    @(negedge clk);
    #1;
    check("lim_fifth_valid", bus.pipe_valid, 1);
    check("lim_fifth_address", bus.pipe_address, 16'h14);
    check("lim_fifth_id", bus.pipe_id, {2'd2, 6'h0});
    bus.req_valid = '0;

    // pipe_stall holds the output register
    apply_reset();
    set_req(0, AW'(16'h2A), LW'(9));
    bus.req_valid = 4'b0001;
    @(negedge clk);
    bus.pipe_stall = 1'b1;
    bus.req_valid  = 4'b0011;
    set_req(0, AW'(16'h55), LW'(1));
    set_req(1, AW'(16'h66), LW'(0));
    for (int n = 0; n < 3; n++) begin
      #1;
      check("hold_pipe_valid", bus.pipe_valid, 1);
      check("hold_pipe_address", bus.pipe_address, 16'h2A);
      check("hold_pipe_id", bus.pipe_id, {2'd0, 6'd9});
      check("hold_req_stall", bus.req_stall, 4'b1111);
      @(negedge clk);
    end
    bus.pipe_stall = 1'b0;
    #1 check("hold_release_stall", bus.req_stall, 4'b1101);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("hold_next_address", bus.pipe_address, 16'h66);
    check("hold_next_id", bus.pipe_id, {2'd1, 6'd0});

    // stalled return to requester 1, then released
    bus.ret_valid  = 1'b1;
    bus.ret_id     = {2'd1, 6'h3};
    bus.resp_stall = 4'b0010;
    #1;
    check("rs_resp_valid", bus.resp_valid, 4'b0010);
    check("rs_ret_stall", bus.ret_stall, 1);
    @(negedge clk);
    #1 check("rs_cnt_held", cnt_of(1), 1);
    bus.resp_stall = 4'b0000;
    #1 check("rs_ret_stall_low", bus.ret_stall, 0);
    @(negedge clk);
    bus.ret_valid = 1'b0;
    #1;
    check("rs_cnt1_dec", cnt_of(1), 0);
    check("rs_cnt0_kept", cnt_of(0), 1);

    // random traffic against the behavioural model
    apply_reset();
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    m_ptr = 0;
    m_pv  = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        bus.req_valid[i]  = ($urandom_range(0, 3) != 0);
        bus.resp_stall[i] = ($urandom_range(0, 3) == 0);
        set_req(i, AW'($urandom), LW'($urandom));
      end
      bus.pipe_stall  = ($urandom_range(0, 3) == 0);
      bus.ret_valid   = ($urandom_range(0, 1) == 1);
      bus.ret_id      = IDW'($urandom);
      bus.ret_address = AW'($urandom);
      #1;

      load = !m_pv || !bus.pipe_stall;
      g = -1;
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (g < 0 && bus.req_valid[i] && m_cnt[i] < MAXO) g = i;
      end
      exp_stall = 4'b1111;
      if (load && g >= 0) exp_stall[g] = 1'b0;
      ridx   = int'(bus.ret_id[IDW-1 -: IW]);
      exp_rv = bus.ret_valid ? (4'b0001 << ridx) : 4'b0000;

      check("rnd_req_stall", bus.req_stall, exp_stall);
      check("rnd_resp_valid", bus.resp_valid, exp_rv);
      check("rnd_ret_stall", bus.ret_stall, bus.ret_valid && bus.resp_stall[ridx]);
      check("rnd_pipe_valid", bus.pipe_valid, m_pv);
      check("rnd_rr_ptr", dbg_rr_ptr, m_ptr);
      if (m_pv) begin
        if (exp_q.size() == 0) check("rnd_scoreboard_empty", 1, 0);
        else check("rnd_pipe_beat", {bus.pipe_address, bus.pipe_id}, exp_q[0]);
      end
      for (int i = 0; i < NR; i++) check("rnd_cnt", cnt_of(i), m_cnt[i]);

      if (m_pv && !bus.pipe_stall) void'(exp_q.pop_front());
      if (bus.ret_valid && !bus.resp_stall[ridx] && m_cnt[ridx] > 0) m_cnt[ridx]--;
      if (load) begin
        m_pv = (g >= 0);
        if (g >= 0) begin
          exp_q.push_back({bus.req_address[g*AW +: AW], IW'(g), bus.req_id[g*LW +: LW]});
          m_cnt[g]++;
          m_ptr = (g + 1) % NR;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
